// File: rtl/div_issue_ctrl_pkg.sv
// Shared encodings for the EX-stage divide issue controller and its optional result cache.
package div_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    DivCtrlIdle  = 2'd0,
    DivCtrlBusy  = 2'd1,
    DivCtrlDone  = 2'd2,
    DivCtrlDrain = 2'd3
  } div_ctrl_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

endpackage

// File: rtl/div_result_cache.sv
// Single-entry cache of the last completed divide {signed, op1, op2, hi, lo}.
// Only compiled when DIV_RESULT_CACHE_EN is defined.
`ifdef DIV_RESULT_CACHE_EN
module div_result_cache
  import div_issue_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lookup_signed,
  input  logic [DATA_W-1:0] lookup_op1,
  input  logic [DATA_W-1:0] lookup_op2,
  input  logic              fill,
  input  logic              fill_signed,
  input  logic [DATA_W-1:0] fill_op1,
  input  logic [DATA_W-1:0] fill_op2,
  input  logic [DATA_W-1:0] fill_hi,
  input  logic [DATA_W-1:0] fill_lo,
  output logic              hit,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  logic              valid;
  logic              signed_tag;
  logic [DATA_W-1:0] op1_tag;
  logic [DATA_W-1:0] op2_tag;
  logic [DATA_W-1:0] hi_data;
  logic [DATA_W-1:0] lo_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid      <= 1'b0;
      signed_tag <= 1'b0;
      op1_tag    <= '0;
      op2_tag    <= '0;
      hi_data    <= '0;
      lo_data    <= '0;
    end else if (fill) begin
      valid      <= 1'b1;
      signed_tag <= fill_signed;
      op1_tag    <= fill_op1;
      op2_tag    <= fill_op2;
      hi_data    <= fill_hi;
      lo_data    <= fill_lo;
    end
  end

  assign hit = valid && (signed_tag == lookup_signed) &&
               (op1_tag == lookup_op1) && (op2_tag == lookup_op2);
  assign hi  = hi_data;
  assign lo  = lo_data;

endmodule
`endif

// File: rtl/div_issue_ctrl.sv
// EX-stage controller for the 32-iteration multi-cycle divider: issue, stall, capture, abort/drain.
// Define DIV_RESULT_CACHE_EN to add a single-entry result cache that skips repeated divides.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_div_valid_i,
  input  logic                ex_div_signed_i,
  input  logic [DATA_W-1:0]   ex_op1_i,
  input  logic [DATA_W-1:0]   ex_op2_i,
  input  logic                flush_i,
  input  logic                ex_stall_i,
  output logic                div_start_o,
  output logic                div_annul_o,
  output logic                div_signed_o,
  output logic [DATA_W-1:0]   div_op1_o,
  output logic [DATA_W-1:0]   div_op2_o,
  input  logic [2*DATA_W-1:0] div_result_i,
  input  logic                div_ready_i,
  output logic                stallreq_o,
  output logic                hilo_we_o,
  output logic [DATA_W-1:0]   hi_o,
  output logic [DATA_W-1:0]   lo_o
);

  localparam int unsigned CntW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  div_ctrl_state_e   state;
  logic              signed_reg;
  logic [DATA_W-1:0] op1_reg;
  logic [DATA_W-1:0] op2_reg;
  logic [DATA_W-1:0] hi_reg;
  logic [DATA_W-1:0] lo_reg;
  logic              hilo_we_reg;
  logic [CntW-1:0]   drain_cnt;

  logic              issue;
  logic              cache_hit;
  logic [DATA_W-1:0] cache_hi;
  logic [DATA_W-1:0] cache_lo;

  assign issue = (state == DivCtrlIdle) && ex_div_valid_i && !flush_i;

`ifdef DIV_RESULT_CACHE_EN
  logic cache_fill;

  // Only results that reach DONE are cached; aborted runs never fill.
  assign cache_fill = (state == DivCtrlBusy) && (div_ready_i == DivResultReady) && !flush_i;

  div_result_cache #(
    .DATA_W (DATA_W)
  ) u_cache (
    .clk           (clk),
    .rst           (rst),
    .lookup_signed (ex_div_signed_i),
    .lookup_op1    (ex_op1_i),
    .lookup_op2    (ex_op2_i),
    .fill          (cache_fill),
    .fill_signed   (signed_reg),
    .fill_op1      (op1_reg),
    .fill_op2      (op2_reg),
    .fill_hi       (div_result_i[2*DATA_W-1:DATA_W]),
    .fill_lo       (div_result_i[DATA_W-1:0]),
    .hit           (cache_hit),
    .hi            (cache_hi),
    .lo            (cache_lo)
  );
`else
  assign cache_hit = 1'b0;
  assign cache_hi  = '0;
  assign cache_lo  = '0;
`endif

  // Start is combinational in the issue cycle so the divider begins without an extra bubble.
  always_comb begin
    div_start_o = DivStop;
    div_annul_o = 1'b0;
    stallreq_o  = 1'b0;
    unique case (state)
      DivCtrlIdle: begin
        div_start_o = (issue && !cache_hit) ? DivStart : DivStop;
        stallreq_o  = issue;
      end
      DivCtrlBusy: begin
        div_start_o = flush_i ? DivStop : DivStart;
        div_annul_o = flush_i;
        stallreq_o  = !flush_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= DivCtrlIdle;
      signed_reg  <= 1'b0;
      op1_reg     <= '0;
      op2_reg     <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      hilo_we_reg <= 1'b0;
      drain_cnt   <= '0;
    end else begin
      unique case (state)
        DivCtrlIdle: begin
          if (issue) begin
            signed_reg <= ex_div_signed_i;
            op1_reg    <= ex_op1_i;
            op2_reg    <= ex_op2_i;
            if (cache_hit) begin
              hi_reg      <= cache_hi;
              lo_reg      <= cache_lo;
              hilo_we_reg <= 1'b1;
              state       <= DivCtrlDone;
            end else begin
              state <= DivCtrlBusy;
            end
          end
        end
        DivCtrlBusy: begin
          if (flush_i) begin
            drain_cnt <= CntW'(DRAIN_CYCLES - 1);
            state     <= DivCtrlDrain;
          end else if (div_ready_i == DivResultReady) begin
            hi_reg      <= div_result_i[2*DATA_W-1:DATA_W];
            lo_reg      <= div_result_i[DATA_W-1:0];
            hilo_we_reg <= 1'b1;
            state       <= DivCtrlDone;
          end
        end
        DivCtrlDone: begin
          if (flush_i || !ex_stall_i) begin
            hilo_we_reg <= 1'b0;
            state       <= DivCtrlIdle;
          end
        end
        DivCtrlDrain: begin
          // Keeps start low long enough for the divider to leave its end/by-zero states.
          if (drain_cnt == '0) begin
            state <= DivCtrlIdle;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  assign div_signed_o = signed_reg;
  assign div_op1_o    = op1_reg;
  assign div_op2_o    = op2_reg;
  assign hilo_we_o    = hilo_we_reg && !flush_i;
  assign hi_o         = hi_reg;
  assign lo_o         = lo_reg;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl with a behavioural model of the team divider.
module tb_div_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        ex_div_valid;
  logic        ex_div_signed;
  logic [31:0] ex_op1;
  logic [31:0] ex_op2;
  logic        flush;
  logic        ex_stall;
  logic        div_start;
  logic        div_annul;
  logic        div_signed;
  logic [31:0] div_op1;
  logic [31:0] div_op2;
  logic [63:0] div_result;
  logic        div_ready;
  logic        stallreq;
  logic        hilo_we;
  logic [31:0] hi;
  logic [31:0] lo;

  div_issue_ctrl #(
    .DATA_W       (32),
    .DRAIN_CYCLES (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ex_div_valid_i  (ex_div_valid),
    .ex_div_signed_i (ex_div_signed),
    .ex_op1_i        (ex_op1),
    .ex_op2_i        (ex_op2),
    .flush_i         (flush),
    .ex_stall_i      (ex_stall),
    .div_start_o     (div_start),
    .div_annul_o     (div_annul),
    .div_signed_o    (div_signed),
    .div_op1_o       (div_op1),
    .div_op2_o       (div_op2),
    .div_result_i    (div_result),
    .div_ready_i     (div_ready),
    .stallreq_o      (stallreq),
    .hilo_we_o       (hilo_we),
    .hi_o            (hi),
    .lo_o            (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Divider model: ready on run cycle 35 (3 for a zero divisor), result only valid with ready.
  logic        m_busy;
  int unsigned m_cnt;

  always @(posedge clk) begin
    if (rst || !div_start || div_annul) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else begin
      m_busy <= 1'b1;
      m_cnt  <= m_cnt + 1;
    end
  end

  assign div_ready = m_busy && (m_cnt == ((div_op2 == 32'd0) ? 32'd3 : 32'd35));

  always_comb begin
    div_result = 64'hDEAD_BEEF_0BAD_F00D;
    if (div_ready) begin
      if (div_op2 == 32'd0) begin
        div_result = 64'd0;
      end else if (div_signed) begin
        div_result = {32'($signed(div_op1) % $signed(div_op2)),
                      32'($signed(div_op1) / $signed(div_op2))};
      end else begin
        div_result = {div_op1 % div_op2, div_op1 / div_op2};
      end
    end
  end

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned due;
  } exp_t;

  exp_t sb[$];
  logic we_prev;
  logic start_prev;
  int   start_runs;

  // Scoreboard consumer: every HI/LO write must match the oldest expected result.
  always @(negedge clk) begin
    if (rst) begin
      we_prev    <= 1'b0;
      start_prev <= 1'b0;
      start_runs <= 0;
    end else begin
      we_prev    <= hilo_we;
      start_prev <= div_start;
      if (div_start && !start_prev) start_runs <= start_runs + 1;
      if (hilo_we) begin
        if (sb.size() == 0) begin
          check("spurious_we", 64'(hilo_we), 64'd0);
        end else begin
          if (!we_prev) check("we_cycle", 64'(cyc), 64'(sb[0].due));
          check("hi", 64'(hi), 64'(sb[0].hi));
          check("lo", 64'(lo), 64'(sb[0].lo));
          if (!ex_stall && !flush) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic drive_issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                             output int unsigned k);
    @(posedge clk); #1;
    ex_div_valid  = 1'b1;
    ex_div_signed = s;
    ex_op1        = a;
    ex_op2        = b;
    k             = cyc;
  endtask

  // Full divide through the divider; stall_n cycles of ex_stall are applied in DONE.
  task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el,
                        input int unsigned lat, input int unsigned stall_n);
    int unsigned k;
    int          runs0;
    runs0 = start_runs;
    drive_issue(s, a, b, k);
    sb.push_back('{eh, el, k + lat});
    @(negedge clk);
    check("issue_start", 64'(div_start), 64'd1);
    check("issue_stallreq", 64'(stallreq), 64'd1);
    @(posedge clk); #1;
    ex_div_valid = 1'b0;
    ex_op1       = $urandom;
    ex_op2       = $urandom;
    for (int i = 1; i < int'(lat); i++) begin
      @(negedge clk);
      check("busy_stallreq", 64'(stallreq), 64'd1);
      check("busy_start", 64'(div_start), 64'd1);
      check("busy_op1", 64'(div_op1), 64'(a));
      check("busy_op2", 64'(div_op2), 64'(b));
      check("busy_signed", 64'(div_signed), 64'(s));
    end
    @(posedge clk); #1;
    ex_stall = (stall_n > 0);
    for (int j = 0; j <= int'(stall_n); j++) begin
      @(negedge clk);
      check("done_we", 64'(hilo_we), 64'd1);
      check("done_start", 64'(div_start), 64'd0);
      check("done_stallreq", 64'(stallreq), 64'd0);
      @(posedge clk); #1;
      ex_stall = (j + 1 < int'(stall_n));
    end
    @(negedge clk);
    check("we_drop", 64'(hilo_we), 64'd0);
    check("start_runs", 64'(start_runs - runs0), 64'd1);
  endtask

  initial begin
    int unsigned k;
    logic [31:0] ra;
    logic [31:0] rb;
    rst           = 1'b1;
    ex_div_valid  = 1'b0;
    ex_div_signed = 1'b0;
    ex_op1        = '0;
    ex_op2        = '0;
    flush         = 1'b0;
    ex_stall      = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_start", 64'(div_start), 64'd0);
    check("rst_annul", 64'(div_annul), 64'd0);
    check("rst_signed", 64'(div_signed), 64'd0);
    check("rst_op1", 64'(div_op1), 64'd0);
    check("rst_op2", 64'(div_op2), 64'd0);
    check("rst_stallreq", 64'(stallreq), 64'd0);
    check("rst_we", 64'(hilo_we), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);

    do_div(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 36, 0);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 36, 0);
    do_div(1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 4, 0);
    do_div(1'b1, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFA, 36, 0);
    do_div(1'b1, 32'd7, 32'd0, 32'd0, 32'd0, 4, 0);

    // Abort at issue+10, then a divide attempted during drain must wait until issue+13.
    drive_issue(1'b0, 32'd12345, 32'd11, k);
    @(posedge clk); #1;
    ex_div_valid = 1'b0;
    while (cyc < k + 10) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    check("flush_annul", 64'(div_annul), 64'd1);
    check("flush_start", 64'(div_start), 64'd0);
    check("flush_stallreq", 64'(stallreq), 64'd0);
    @(posedge clk); #1;
    flush         = 1'b0;
    ex_div_valid  = 1'b1;
    ex_div_signed = 1'b0;
    ex_op1        = 32'd9;
    ex_op2        = 32'd3;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("drain_start", 64'(div_start), 64'd0);
      check("drain_annul", 64'(div_annul), 64'd0);
      check("drain_stallreq", 64'(stallreq), 64'd0);
      if (i == 0) begin
        @(posedge clk); #1;
      end
    end
    check("drain_end_cycle", 64'(cyc), 64'(k + 12));
    do_div(1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 36, 0);

    do_div(1'b0, 32'd1000, 32'd33, 32'd10, 32'd30, 36, 3);

    for (int t = 0; t < 2; t++) begin
      ra = $urandom;
      rb = $urandom_range(1, 5000);
      do_div(1'b0, ra, rb, ra % rb, ra / rb, 36, 0);
    end

    // Reset in the middle of a run returns to IDLE without any HI/LO write.
    drive_issue(1'b0, 32'd77, 32'd5, k);
    @(posedge clk); #1;
    ex_div_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_stallreq", 64'(stallreq), 64'd0);
    check("midrst_start", 64'(div_start), 64'd0);
    repeat (40) @(negedge clk);
    check("midrst_we", 64'(hilo_we), 64'd0);

`ifdef DIV_RESULT_CACHE_EN
    do_div(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 36, 0);
    begin
      int runs0;
      runs0 = start_runs;
      drive_issue(1'b0, 32'd100, 32'd7, k);
      sb.push_back('{32'd2, 32'd14, k + 1});
      @(negedge clk);
      check("hit_issue_start", 64'(div_start), 64'd0);
      check("hit_issue_stallreq", 64'(stallreq), 64'd1);
      @(posedge clk); #1;
      ex_div_valid = 1'b0;
      @(negedge clk);
      check("hit_we", 64'(hilo_we), 64'd1);
      check("hit_start", 64'(div_start), 64'd0);
      check("hit_stallreq", 64'(stallreq), 64'd0);
      @(negedge clk);
      check("hit_we_drop", 64'(hilo_we), 64'd0);
      check("hit_start_runs", 64'(start_runs - runs0), 64'd0);
    end
`endif

    @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- EX-stage controller between the decoded divide instruction and the 32-iteration multi-cycle divider.
- Latches operands and drives the divider's start/annul/signed/operand inputs. Holds operands stable until the divider reports ready.
- Raises the pipeline stall request while the divide runs.
- Captures the 64-bit divider result {remainder, quotient} and presents a one-shot HI/LO write to EX/MEM.
- Handles flush and later-stage stall, and drains the divider after an abort.

Parameters:
- DATA_W, 32, operand width; only 32 is supported by the divider.
- DRAIN_CYCLES, 2, cycles div_start_o is held low after an abort before a new issue is allowed.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_div_valid_i  in  1  a DIV/DIVU instruction is present in EX
- ex_div_signed_i  in  1  1 = DIV, 0 = DIVU
- ex_op1_i  in  DATA_W  dividend
- ex_op2_i  in  DATA_W  divisor
- flush_i  in  1  pipeline flush (exception/branch)
- ex_stall_i  in  1  stall from a later stage
- div_start_o  out  1  divider start, level-held during the run
- div_annul_o  out  1  divider abort, one-cycle pulse
- div_signed_o  out  1  latched signed flag
- div_op1_o  out  DATA_W  latched dividend
- div_op2_o  out  DATA_W  latched divisor
- div_result_i  in  2*DATA_W  {remainder, quotient} from the divider
- div_ready_i  in  1  divider result valid
- stallreq_o  out  1  stall request to the pipeline controller (combinational)
- hilo_we_o  out  1  HI/LO write enable
- hi_o  out  DATA_W  remainder
- lo_o  out  DATA_W  quotient

Behaviour:
- Reset: state IDLE; all registered outputs 0; operand registers 0; drain counter 0.
- Reset mid-run forces IDLE. The divider shares rst, so no drain is needed after reset.
- FSM states: IDLE, BUSY, DONE, DRAIN.
- IDLE:
  - Issue when ex_div_valid_i & !flush_i. Operands and signed flag are latched on the issue edge.
  - In the issue cycle, div_start_o (combinational from IDLE) and stallreq_o are 1. Next state BUSY.
  - div_ready_i is ignored in IDLE.
- BUSY:
  - div_start_o = 1; stallreq_o = !flush_i.
  - Operand and signed registers are frozen; the divider re-reads the operands for sign correction.
  - flush_i: div_annul_o = 1 and div_start_o = 0 that cycle, result discarded, go DRAIN.
  - div_ready_i & !flush_i: capture div_result_i[63:32] into hi, [31:0] into lo, go DONE.
  - flush_i and div_ready_i in the same cycle: flush wins, go DRAIN.
- DONE:
  - hilo_we_o = 1 with registered hi_o/lo_o; div_start_o = 0; stallreq_o = 0.
  - ex_stall_i: stay in DONE, keep hilo_we_o and the data stable, do not reissue.
  - Otherwise go IDLE. The divider returns to free on this edge because start is low.
  - flush_i in DONE: drop hilo_we_o, go IDLE.
- DRAIN: div_start_o = 0 and stallreq_o = 0 for DRAIN_CYCLES cycles, then IDLE. This guarantees the divider leaves its end/by-zero states before the next start.
- Latency with the team divider:
  - hilo_we_o asserts 36 cycles after the issue cycle; stallreq_o is high for issue through issue+35.
  - Divisor zero: hilo_we_o at issue+4 with hi = lo = 0.
- Signed/unsigned arithmetic is done entirely in the divider; this block never modifies the data.

Optional Feature:
- Macro: DIV_RESULT_CACHE_EN.
- With the macro defined:
  - A single-entry cache stores {valid, signed, op1, op2, hi, lo} from the last completed (not aborted) divide.
  - An issue that matches the cache goes straight to DONE, with hilo_we_o on the next cycle and stallreq_o high only in the issue cycle.
  - div_start_o is never asserted for a hit.
  - Cache valid is cleared on rst; aborts do not fill the cache.
- Without the macro: no cache storage; every issue runs the divider.

Decomposition:
- Shared package (defines.vh):
  - controller state encodings DivCtrlIdle/Busy/Done/Drain;
  - existing DivStart/DivStop and DivResultReady/NotReady;
  - ZeroWord.
- Sub-module div_result_cache, instantiated only under DIV_RESULT_CACHE_EN.
  - Handles the compare and fill, and outputs hit/hi/lo.

Test Plan:
1. DIVU 100/7 → hi=2, lo=14; hilo_we_o for exactly 1 cycle at issue+36; stallreq_o high issue..issue+35.
2. DIV 0xFFFFFFF9 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; div_op1_o stable through the whole BUSY period.
3. DIVU 5/0 → hi=lo=0; hilo_we_o at issue+4.
4. flush_i at issue+10:
   - div_annul_o pulse for 1 cycle, no hilo_we_o, div_start_o low for 2 cycles.
   - A new DIVU 9/3 issued at issue+13 returns lo=3, hi=0.
5. ex_stall_i held 3 cycles in DONE → hilo_we_o held 4 cycles with constant data; only one div_start_o run observed.
6. DIV_RESULT_CACHE_EN defined, DIVU 100/7 repeated → second issue gives hilo_we_o at issue+1, div_start_o never asserted, hi=2, lo=14.
